// File: rtl/mb_load_ctl_pkg.sv
// mb_ctl_pkg: shared widths, MB source codes and controller state encodings
package mb_ctl_pkg;
    localparam int N_WORDS  = 4;
    localparam int CH_ADR_W = 7;
    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        MEM   = 3'd1,
        CACHE = 3'd2,
        AR    = 3'd3,
        CHBUF = 3'd4
    } mb_src_t;
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MEM  = 3'd1,
        S_CH   = 3'd2,
        S_CWB  = 3'd3,
        S_ST   = 3'd4
    } mb_state_t;
endpackage

// File: rtl/mb_load_ctl_if.sv
// mb_load_ctl_if: requester handshakes and MB load controls of the MBox load controller
//   master: requesters (drive requests, memory return strobes, address counter controls)
//   slave : mb_load_ctl (drives source select, hold enables, address, acks, status)
interface mb_load_ctl_if;
    import mb_ctl_pkg::*;
    logic                mem_rd_req_h;
    logic [1:0]          mem_start_wd_h;
    logic                mem_data_valid_h;
    logic                nxm_any_l;
    logic                ch_req_h;
    logic                ch_adr_ld_h;
    logic [CH_ADR_W-1:0] ch_adr_in_h;
    logic                ch_reverse_h;
    logic                cwb_req_h;
    logic                st_req_h;
    logic [1:0]          st_wd_h;
    logic [2:0]          mb_in_sel_h;
    logic [N_WORDS-1:0]  mb_hold_in_h;
    logic [CH_ADR_W-1:0] ch_buf_adr_h;
    logic                ch_ack_h;
    logic                cwb_ack_h;
    logic                st_ack_h;
    logic                mem_done_h;
    logic                mem_err_h;
    logic                busy_h;
    modport master (
        output mem_rd_req_h, mem_start_wd_h, mem_data_valid_h, nxm_any_l,
               ch_req_h, ch_adr_ld_h, ch_adr_in_h, ch_reverse_h,
               cwb_req_h, st_req_h, st_wd_h,
        input  mb_in_sel_h, mb_hold_in_h, ch_buf_adr_h,
               ch_ack_h, cwb_ack_h, st_ack_h, mem_done_h, mem_err_h, busy_h
    );
    modport slave (
        input  mem_rd_req_h, mem_start_wd_h, mem_data_valid_h, nxm_any_l,
               ch_req_h, ch_adr_ld_h, ch_adr_in_h, ch_reverse_h,
               cwb_req_h, st_req_h, st_wd_h,
        output mb_in_sel_h, mb_hold_in_h, ch_buf_adr_h,
               ch_ack_h, cwb_ack_h, st_ack_h, mem_done_h, mem_err_h, busy_h
    );
endinterface

// File: rtl/mb_load_ctl_ch_adr_ctr.sv
// mb_ch_adr_ctr: channel-buffer address counter, load beats step, wraps both ways
//   clk, rst      : clock, asynchronous active-high reset
//   ld, ld_val    : load the counter
//   step, rev     : advance by one, decrementing when rev is high
//   adr           : current address
module mb_ch_adr_ctr
    import mb_ctl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ld,
    input  logic [CH_ADR_W-1:0] ld_val,
    input  logic                step,
    input  logic                rev,
    output logic [CH_ADR_W-1:0] adr
);
    logic [CH_ADR_W-1:0] adr_q, adr_d;
    always_comb adr_d = ld ? ld_val : step ? (rev ? adr_q - 1'b1 : adr_q + 1'b1) : adr_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) adr_q <= '0;
        else adr_q <= adr_d;
    assign adr = adr_q;
endmodule

// File: rtl/mb_load_ctl.sv
// mb_load_ctl: arbitrates and sequences the four-word MB loads
//   clk, reset_h : MBox clock, asynchronous active-high reset
//   bus (slave)  : memory return, channel buffer, cache writeback and store requests in;
//                  MB source select, per-word hold enables, channel-buffer address,
//                  ack/done/error pulses and busy out
module mb_load_ctl
    import mb_ctl_pkg::*;
#(
    parameter int MEM_TMO = 64
) (
    input logic          clk,
    input logic          reset_h,
    mb_load_ctl_if.slave bus
);
    localparam int TMO_W = $clog2(MEM_TMO + 1);
    localparam logic [2:0] ST_IDLE = S_IDLE;
    localparam logic [2:0] ST_MEM  = S_MEM;
    localparam logic [2:0] ST_CH   = S_CH;
    localparam logic [2:0] ST_CWB  = S_CWB;
    localparam logic [2:0] ST_ST   = S_ST;

    logic [2:0]       state_q, state_d;
    logic [1:0]       wd_q, wd_d, cnt_q, cnt_d, pend_wd_q, pend_wd_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             rr_q, rr_d, pend_q, pend_d;
    logic             ch_ack_q, ch_ack_d, cwb_ack_q, cwb_ack_d, st_ack_q, st_ack_d;
    logic             done_q, done_d, err_q, err_d;
    logic             load, ch_r, cwb_r, st_r;
    logic [2:0]       src;

    // nxm suppresses the load even when a valid strobe is present
    assign load  = state_q == ST_MEM && bus.mem_data_valid_h && bus.nxm_any_l;
    // a requester's level during its own ack cycle is stale and must not re-grant
    assign ch_r  = bus.ch_req_h  && !ch_ack_q;
    assign cwb_r = bus.cwb_req_h && !cwb_ack_q;
    assign st_r  = bus.st_req_h  && !st_ack_q;

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        rr_d      = rr_q;
        pend_d    = pend_q;
        pend_wd_d = pend_wd_q;
        ch_ack_d  = 1'b0;
        cwb_ack_d = 1'b0;
        st_ack_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        // only the first busy-time memory request is kept; a second is dropped silently
        if (state_q != ST_IDLE && bus.mem_rd_req_h && !pend_q) begin
            pend_d    = 1'b1;
            pend_wd_d = bus.mem_start_wd_h;
        end
        case (state_q)
            ST_IDLE: begin
                wd_d  = '0;
                cnt_d = '0;
                tmo_d = '0;
                if (pend_q || bus.mem_rd_req_h) begin
                    state_d = ST_MEM;
                    pend_d  = 1'b0;
                    wd_d    = pend_q ? pend_wd_q : bus.mem_start_wd_h;
                end else if (st_r) begin
                    state_d = ST_ST;
                end else if (ch_r && (!cwb_r || rr_q)) begin
                    state_d = ST_CH;
                    rr_d    = cwb_r ? 1'b0 : rr_q;
                end else if (cwb_r) begin
                    state_d = ST_CWB;
                    rr_d    = ch_r ? 1'b1 : rr_q;
                end
            end
            ST_MEM: begin
                if (!bus.nxm_any_l) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (bus.mem_data_valid_h) begin
                    wd_d    = wd_q + 2'd1;
                    cnt_d   = cnt_q + 2'd1;
                    tmo_d   = '0;
                    done_d  = cnt_q == 2'd3;
                    state_d = cnt_q == 2'd3 ? ST_IDLE : ST_MEM;
                end else if (tmo_q == TMO_W'(MEM_TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_CH, ST_CWB: begin
                wd_d      = wd_q + 2'd1;
                ch_ack_d  = wd_q == 2'd3 && state_q == ST_CH;
                cwb_ack_d = wd_q == 2'd3 && state_q == ST_CWB;
                state_d   = wd_q == 2'd3 ? ST_IDLE : state_q;
            end
            ST_ST: begin
                st_ack_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_h)
        if (reset_h) begin
            state_q   <= ST_IDLE;
            wd_q      <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            rr_q      <= 1'b1;
            pend_q    <= 1'b0;
            pend_wd_q <= '0;
            ch_ack_q  <= 1'b0;
            cwb_ack_q <= 1'b0;
            st_ack_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            rr_q      <= rr_d;
            pend_q    <= pend_d;
            pend_wd_q <= pend_wd_d;
            ch_ack_q  <= ch_ack_d;
            cwb_ack_q <= cwb_ack_d;
            st_ack_q  <= st_ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end

    assign src = state_q == ST_MEM ? (load ? MEM : HOLD) :
                 state_q == ST_CH  ? CHBUF :
                 state_q == ST_CWB ? CACHE :
                 state_q == ST_ST  ? AR : HOLD;

    // hold enables are derived from the select so they can never fire under HOLD
    assign bus.mb_in_sel_h  = src;
    assign bus.mb_hold_in_h = src == HOLD ? '0 :
                              N_WORDS'(1) << (state_q == ST_ST ? bus.st_wd_h : wd_q);
    assign bus.ch_ack_h     = ch_ack_q;
    assign bus.cwb_ack_h    = cwb_ack_q;
    assign bus.st_ack_h     = st_ack_q;
    assign bus.mem_done_h   = done_q;
    assign bus.mem_err_h    = err_q;
    assign bus.busy_h       = state_q != ST_IDLE;

    mb_ch_adr_ctr u_ch_adr_ctr (
        .clk    (clk),
        .rst    (reset_h),
        .ld     (bus.ch_adr_ld_h),
        .ld_val (bus.ch_adr_in_h),
        .step   (state_q == ST_CH),
        .rev    (bus.ch_reverse_h),
        .adr    (bus.ch_buf_adr_h)
    );
endmodule

// File: tb/tb_mb_load_ctl.sv
// tb_mb_load_ctl: directed scenarios for the MB load controller
module tb_mb_load_ctl;
    import mb_ctl_pkg::*;

    logic clk = 1'b0;
    logic reset_h = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mb_load_ctl_if bus ();

    mb_load_ctl dut (
        .clk     (clk),
        .reset_h (reset_h),
        .bus     (bus.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        bus.mem_rd_req_h     = 1'b0;
        bus.mem_start_wd_h   = 2'd0;
        bus.mem_data_valid_h = 1'b0;
        bus.nxm_any_l        = 1'b1;
        bus.ch_req_h         = 1'b0;
        bus.ch_adr_ld_h      = 1'b0;
        bus.ch_adr_in_h      = '0;
        bus.ch_reverse_h     = 1'b0;
        bus.cwb_req_h        = 1'b0;
        bus.st_req_h         = 1'b0;
        bus.st_wd_h          = 2'd0;
    endtask

    task automatic test_reset;
        idle_in();
        reset_h = 1'b1;
        #12;
        total++;
        if (bus.mb_in_sel_h !== 3'd0) begin
            bad++;
            $display("FAIL reset_sel: got %0d want 0", bus.mb_in_sel_h);
        end
        total++;
        if (bus.mb_hold_in_h !== 4'b0000) begin
            bad++;
            $display("FAIL reset_hold: got %b want 0000", bus.mb_hold_in_h);
        end
        total++;
        if (bus.ch_buf_adr_h !== 7'd0) begin
            bad++;
            $display("FAIL reset_adr: got %0d want 0", bus.ch_buf_adr_h);
        end
        total++;
        if ({bus.ch_ack_h, bus.cwb_ack_h, bus.st_ack_h, bus.mem_done_h, bus.mem_err_h, bus.busy_h} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {bus.ch_ack_h, bus.cwb_ack_h, bus.st_ack_h, bus.mem_done_h, bus.mem_err_h, bus.busy_h});
        end
        @(negedge clk);
        reset_h = 1'b0;
    endtask

    task automatic test_mem_return;
        logic [5:0] v;
        logic [3:0] eh [6];
        v  = 6'b110110;
        eh = '{4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0010};
        tick;
        bus.mem_rd_req_h   = 1'b1;
        bus.mem_start_wd_h = 2'd2;
        for (int i = 0; i < 6; i++) begin
            tick;
            bus.mem_rd_req_h     = 1'b0;
            bus.mem_data_valid_h = v[i];
            #3;
            total++;
            if (bus.mb_in_sel_h !== (v[i] ? 3'd1 : 3'd0) || bus.mb_hold_in_h !== eh[i] || bus.busy_h !== 1'b1) begin
                bad++;
                $display("FAIL mem_word%0d: got sel=%0d hold=%b busy=%b want sel=%0d hold=%b busy=1",
                         i, bus.mb_in_sel_h, bus.mb_hold_in_h, bus.busy_h, v[i] ? 1 : 0, eh[i]);
            end
        end
        tick;
        bus.mem_data_valid_h = 1'b0;
        #3;
        total++;
        if (bus.mem_done_h !== 1'b1 || bus.busy_h !== 1'b0 || bus.mem_err_h !== 1'b0) begin
            bad++;
            $display("FAIL mem_done: got done=%b busy=%b err=%b want 1 0 0", bus.mem_done_h, bus.busy_h, bus.mem_err_h);
        end
        tick;
        #3;
        total++;
        if (bus.mem_done_h !== 1'b0) begin
            bad++;
            $display("FAIL mem_done_pulse: got %b want 0", bus.mem_done_h);
        end
    endtask

    task automatic test_mem_nxm;
        tick;
        bus.mem_rd_req_h   = 1'b1;
        bus.mem_start_wd_h = 2'd0;
        tick;
        bus.mem_rd_req_h     = 1'b0;
        bus.mem_data_valid_h = 1'b1;
        #3;
        total++;
        if (bus.mb_hold_in_h !== 4'b0001) begin
            bad++;
            $display("FAIL nxm_w0: got %b want 0001", bus.mb_hold_in_h);
        end
        tick;
        #3;
        total++;
        if (bus.mb_hold_in_h !== 4'b0010) begin
            bad++;
            $display("FAIL nxm_w1: got %b want 0010", bus.mb_hold_in_h);
        end
        tick;
        bus.nxm_any_l = 1'b0;
        #3;
        total++;
        if (bus.mb_in_sel_h !== 3'd0 || bus.mb_hold_in_h !== 4'b0000) begin
            bad++;
            $display("FAIL nxm_noload: got sel=%0d hold=%b want 0 0000", bus.mb_in_sel_h, bus.mb_hold_in_h);
        end
        tick;
        bus.nxm_any_l        = 1'b1;
        bus.mem_data_valid_h = 1'b0;
        #3;
        total++;
        if (bus.mem_err_h !== 1'b1 || bus.busy_h !== 1'b0 || bus.mem_done_h !== 1'b0) begin
            bad++;
            $display("FAIL nxm_err: got err=%b busy=%b done=%b want 1 0 0", bus.mem_err_h, bus.busy_h, bus.mem_done_h);
        end
    endtask

    task automatic test_mem_timeout;
        tick;
        bus.mem_rd_req_h = 1'b1;
        tick;
        bus.mem_rd_req_h = 1'b0;
        for (int i = 1; i < 64; i++) tick;
        #3;
        total++;
        if (bus.busy_h !== 1'b1 || bus.mem_err_h !== 1'b0) begin
            bad++;
            $display("FAIL tmo_early: got busy=%b err=%b want 1 0", bus.busy_h, bus.mem_err_h);
        end
        tick;
        #3;
        total++;
        if (bus.mem_err_h !== 1'b1 || bus.busy_h !== 1'b0) begin
            bad++;
            $display("FAIL tmo_err: got err=%b busy=%b want 1 0", bus.mem_err_h, bus.busy_h);
        end
    endtask

    task automatic test_ch_adr;
        logic [6:0] sa [2];
        logic [6:0] ea [2][5];
        sa = '{7'd126, 7'd1};
        ea = '{'{7'd126, 7'd127, 7'd0, 7'd1, 7'd2}, '{7'd1, 7'd0, 7'd127, 7'd126, 7'd125}};
        for (int c = 0; c < 2; c++) begin
            tick;
            bus.ch_adr_ld_h  = 1'b1;
            bus.ch_adr_in_h  = sa[c];
            bus.ch_reverse_h = c == 1;
            tick;
            bus.ch_adr_ld_h = 1'b0;
            bus.ch_req_h    = 1'b1;
            for (int w = 0; w < 4; w++) begin
                tick;
                #3;
                total++;
                if (bus.mb_in_sel_h !== 3'd4 || bus.mb_hold_in_h !== 4'(1 << w) || bus.ch_buf_adr_h !== ea[c][w]) begin
                    bad++;
                    $display("FAIL ch%0d_w%0d: got sel=%0d hold=%b adr=%0d want 4 %b %0d",
                             c, w, bus.mb_in_sel_h, bus.mb_hold_in_h, bus.ch_buf_adr_h, 4'(1 << w), ea[c][w]);
                end
            end
            tick;
            bus.ch_req_h = 1'b0;
            #3;
            total++;
            if (bus.ch_ack_h !== 1'b1 || bus.ch_buf_adr_h !== ea[c][4] || bus.busy_h !== 1'b0) begin
                bad++;
                $display("FAIL ch%0d_ack: got ack=%b adr=%0d busy=%b want 1 %0d 0",
                         c, bus.ch_ack_h, bus.ch_buf_adr_h, bus.busy_h, ea[c][4]);
            end
        end
        bus.ch_reverse_h = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [2:0] es [17];
        logic [2:0] ea [17];
        es = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 3'd3, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0,
               3'd4, 3'd4, 3'd4, 3'd4, 3'd0};
        ea = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000,
               3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
        tick;
        bus.ch_req_h  = 1'b1;
        bus.cwb_req_h = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick;
            if (k == 2) begin
                bus.st_req_h = 1'b1;
                bus.st_wd_h  = 2'd1;
            end
            if (k == 7) bus.st_req_h = 1'b0;
            if (k == 17) begin
                bus.ch_req_h  = 1'b0;
                bus.cwb_req_h = 1'b0;
            end
            #3;
            total++;
            if (bus.mb_in_sel_h !== es[k-1] || {bus.ch_ack_h, bus.cwb_ack_h, bus.st_ack_h} !== ea[k-1]) begin
                bad++;
                $display("FAIL rr_c%0d: got sel=%0d acks=%b want sel=%0d acks=%b", k, bus.mb_in_sel_h,
                         {bus.ch_ack_h, bus.cwb_ack_h, bus.st_ack_h}, es[k-1], ea[k-1]);
            end
            if (k == 6) begin
                total++;
                if (bus.mb_hold_in_h !== 4'b0010) begin
                    bad++;
                    $display("FAIL rr_st_hold: got %b want 0010", bus.mb_hold_in_h);
                end
            end
        end
    endtask

    task automatic test_mem_during_cwb;
        logic [2:0] es [13];
        logic [3:0] eh [13];
        logic [3:0] ep [13];
        es = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd3, 3'd0, 3'd0};
        eh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0100,
               4'b0000, 4'b0100, 4'b0000, 4'b0000};
        ep = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
               4'b1000, 4'b0000, 4'b0001, 4'b0000};
        tick;
        bus.cwb_req_h = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick;
            bus.mem_rd_req_h     = k == 2 || k == 4;
            bus.mem_start_wd_h   = k == 2 ? 2'd3 : 2'd0;
            bus.mem_data_valid_h = k >= 6 && k <= 9;
            if (k == 2) begin
                bus.st_req_h = 1'b1;
                bus.st_wd_h  = 2'd2;
            end
            if (k == 5) bus.cwb_req_h = 1'b0;
            if (k == 12) bus.st_req_h = 1'b0;
            #3;
            total++;
            if (bus.mb_in_sel_h !== es[k-1] || bus.mb_hold_in_h !== eh[k-1] ||
                {bus.mem_done_h, bus.mem_err_h, bus.cwb_ack_h, bus.st_ack_h} !== ep[k-1]) begin
                bad++;
                $display("FAIL pend_c%0d: got sel=%0d hold=%b pulses=%b want sel=%0d hold=%b pulses=%b",
                         k, bus.mb_in_sel_h, bus.mb_hold_in_h,
                         {bus.mem_done_h, bus.mem_err_h, bus.cwb_ack_h, bus.st_ack_h}, es[k-1], eh[k-1], ep[k-1]);
            end
        end
        total++;
        if (bus.busy_h !== 1'b0) begin
            bad++;
            $display("FAIL pend_final_busy: got %b want 0", bus.busy_h);
        end
    endtask

    task automatic test_reset_mid;
        tick;
        bus.cwb_req_h = 1'b1;
        tick;
        #3;
        total++;
        if (bus.mb_in_sel_h !== 3'd2 || bus.mb_hold_in_h !== 4'b0001) begin
            bad++;
            $display("FAIL rst_cwb_w0: got sel=%0d hold=%b want 2 0001", bus.mb_in_sel_h, bus.mb_hold_in_h);
        end
        tick;
        #2;
        reset_h = 1'b1;
        #1;
        total++;
        if (bus.mb_in_sel_h !== 3'd0 || bus.mb_hold_in_h !== 4'b0000 || bus.ch_buf_adr_h !== 7'd0 ||
            {bus.ch_ack_h, bus.cwb_ack_h, bus.st_ack_h, bus.mem_done_h, bus.mem_err_h, bus.busy_h} !== 6'b0) begin
            bad++;
            $display("FAIL rst_async: got sel=%0d hold=%b adr=%0d flags=%b want all 0",
                     bus.mb_in_sel_h, bus.mb_hold_in_h, bus.ch_buf_adr_h,
                     {bus.ch_ack_h, bus.cwb_ack_h, bus.st_ack_h, bus.mem_done_h, bus.mem_err_h, bus.busy_h});
        end
        bus.cwb_req_h = 1'b0;
        tick;
        reset_h = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            #3;
            total++;
            if (bus.cwb_ack_h !== 1'b0 || bus.busy_h !== 1'b0 || bus.mb_hold_in_h !== 4'b0000) begin
                bad++;
                $display("FAIL rst_quiet%0d: got ack=%b busy=%b hold=%b want 0 0 0000",
                         i, bus.cwb_ack_h, bus.busy_h, bus.mb_hold_in_h);
            end
        end
        tick;
        bus.cwb_req_h = 1'b1;
        tick;
        #3;
        total++;
        if (bus.mb_in_sel_h !== 3'd2 || bus.mb_hold_in_h !== 4'b0001) begin
            bad++;
            $display("FAIL rst_restart: got sel=%0d hold=%b want 2 0001", bus.mb_in_sel_h, bus.mb_hold_in_h);
        end
        tick;
        tick;
        tick;
        tick;
        bus.cwb_req_h = 1'b0;
        #3;
        total++;
        if (bus.cwb_ack_h !== 1'b1) begin
            bad++;
            $display("FAIL rst_restart_ack: got %b want 1", bus.cwb_ack_h);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mem_return();
        test_mem_nxm();
        test_mem_timeout();
        test_ch_adr();
        test_back_to_back();
        test_mem_during_cwb();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mb_load_ctl.md
Name: mb_load_ctl

Overview:
- Sequences and arbitrates loads into the four-word MBox memory buffer (MB0-MB3).
- Per cycle, drives the MB input-source select and the per-word load enables.
- Serves four requesters: memory read return, channel-buffer transfer, cache writeback and EBOX store.
- Also owns the 7-bit channel-buffer address counter and the memory-return timeout.

Parameters:
- N_WORDS, 4, MB words per transfer; fixed 4, sets hold-vector width.
- CH_ADR_W, 7, channel-buffer address width.
- MEM_TMO, 64, cycles without a memory strobe before timeout abort.

Ports:
- clk  in  1  MBox clock
- reset_h  in  1  asynchronous active-high reset
- mem_rd_req_h  in  1  memory read return expected (pulse)
- mem_start_wd_h  in  2  first word address of memory return
- mem_data_valid_h  in  1  memory word present on mem_data_in this cycle
- nxm_any_l  in  1  nonexistent memory (active low)
- ch_req_h  in  1  channel wants 4 words from channel buffer into MB (level until ack)
- ch_adr_ld_h  in  1  load channel-buffer address counter
- ch_adr_in_h  in  CH_ADR_W  value for counter load
- ch_reverse_h  in  1  counter decrements instead of increments
- cwb_req_h  in  1  cache writeback wants 4 words (level until ack)
- st_req_h  in  1  EBOX store of AR into one word (level until ack)
- st_wd_h  in  2  target word of store
- mb_in_sel_h  out  3  MB source code, see Behaviour
- mb_hold_in_h  out  N_WORDS  one-hot per-word load enable
- ch_buf_adr_h  out  CH_ADR_W  channel-buffer address
- ch_ack_h, cwb_ack_h, st_ack_h  out  1 each  one-cycle grant-complete pulse
- mem_done_h  out  1  memory return complete pulse
- mem_err_h  out  1  NXM or timeout abort pulse
- busy_h  out  1  state is not IDLE

Behaviour:
- Source codes: 0 HOLD, 1 MEM, 2 CACHE, 3 AR, 4 CHBUF; 5-7 are never driven.
- Reset values: all outputs 0, ch_buf_adr_h = 0, state IDLE, round-robin pointer points at CH.
- States: IDLE, MEM, CH, CWB, ST.
- IDLE priority: mem_rd_req_h > st_req_h > round-robin(ch_req_h, cwb_req_h). The loser of CH/CWB wins next contention.
- Grant decision is registered: request in cycle N puts the state in cycle N+1.
- mb_in_sel_h and mb_hold_in_h are combinational from state, word counter and valid.
- MEM state:
  - Word pointer loads mem_start_wd_h and the count loads 0.
  - Each mem_data_valid_h cycle: sel=MEM, hold_in bit[pointer]=1, pointer += 1 mod 4, count += 1. With no valid: sel=HOLD, hold_in=0.
  - After the 4th valid: mem_done_h pulses the next cycle, return to IDLE.
  - nxm_any_l low in MEM: no load that cycle, mem_err_h pulses, return to IDLE.
  - MEM_TMO consecutive cycles without valid: same abort. The timeout counter clears on each valid.
- CH state: 4 consecutive cycles, word 0..3.
  - Each cycle: sel=CHBUF, hold_in one-hot, ch_buf_adr_h ±1 after each word.
  - Counter wraps 127↔0.
  - ch_ack_h pulses in the cycle after word 3.
- CWB state: 4 consecutive cycles, sel=CACHE, words 0..3; then cwb_ack_h pulses.
- ST state: 1 cycle, sel=AR, hold_in bit[st_wd_h]; st_ack_h pulses the next cycle.
- Ack cycle is IDLE: a new grant may be decided that same cycle, but a requester must drop its request on ack. Its level in the ack cycle is ignored.
- Counter load and step:
  - ch_adr_ld_h is honoured in any state and wins over the CH-state step in the same cycle.
  - ch_reverse_h is sampled per step.
- mem_rd_req_h arriving while not IDLE is latched as pending and served first on return to IDLE. A second pulse while pending is an error: it is ignored and mem_err_h is not asserted.
- Reset mid-transfer: immediate IDLE, no ack or done pulse, and no partial-word loads after reset.
- At most one hold_in bit is high in any cycle.
- hold_in is nonzero only when sel is not HOLD.

Decomposition:
- Package mb_ctl_pkg holds:
  - enum mb_src_t (HOLD, MEM, CACHE, AR, CHBUF)
  - enum mb_state_t
  - constants N_WORDS and CH_ADR_W
- Sub-module mb_ch_adr_ctr: up/down counter with load and wrap for the channel-buffer address.

Test Plan:
- Memory return with start word 2 and valids on cycles 3, 4, 6, 7 → hold_in 0100, 1000, 0001, 0010 with sel=1; idle cycle 5 shows sel=0. mem_done_h follows the 4th valid.
- nxm_any_l low before the 3rd valid → only 2 loads, mem_err_h pulses, busy_h drops; no 70-cycle stall. Separately, no valid for 64 cycles → mem_err_h.
- Channel-buffer address loaded to 126, ch_reverse_h=0, ch_req_h → adr 126, 127, 0, 1, final value 2. Repeat with reverse from 1 → 1, 0, 127, 126.
- ch_req_h and cwb_req_h asserted together, held continuously → grants alternate CH, CWB, CH, with an ack between each. st_req_h raised mid-CH is served before the next CWB.
- mem_rd_req_h during CWB → CWB completes, MEM is served next ahead of a pending st_req_h.
- reset_h asserted in the 2nd CWB cycle → all outputs 0 asynchronously, no cwb_ack_h. Re-request after release restarts at word 0.
